// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register file write port.
// The master modport is the requester/register-file side; the slave modport is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic                     req0_valid;
    logic [ADDR_W-1:0]        req0_addr;
    logic [DATA_W-1:0]        req0_data;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [ADDR_W-1:0]        req1_addr;
    logic [DATA_W-1:0]        req1_data;
    logic                     req1_ready;
    logic                     we3;
    logic [ADDR_W-1:0]        wa3;
    logic [DATA_W-1:0]        wd3;
    logic [(1<<ADDR_W)-1:0]   pending;
    logic                     busy;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, we3, wa3, wd3, pending, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, we3, wa3, wd3, pending, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between two one-entry writeback buffers,
// issuing oldest-first with a round-robin tie-break when both load on the same edge.
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int                NREQ  = 2;
    localparam int                NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] XZR   = '1;

    logic [NREQ-1:0]              w_valid, w_ready, w_gnt, w_load, w_stay;
    logic [NREQ-1:0][ADDR_W-1:0]  w_addr;
    logic [NREQ-1:0][DATA_W-1:0]  w_data;

    logic [NREQ-1:0]              r_full;
    logic [NREQ-1:0][ADDR_W-1:0]  r_addr;
    logic [NREQ-1:0][DATA_W-1:0]  r_data;
    logic                         r_first;
    logic                         r_rr;

    logic                         w_we3;
    logic [ADDR_W-1:0]            w_wa3;
    logic [DATA_W-1:0]            w_wd3;
    logic [NREGS-1:0]             w_pending;

    assign w_valid = {bus.req1_valid, bus.req0_valid};
    assign w_addr  = {bus.req1_addr,  bus.req0_addr};
    assign w_data  = {bus.req1_data,  bus.req0_data};

    // Grant depends on registered state only, so ready never combinationally follows valid.
    assign w_gnt[0] = r_full[0] & (~r_full[1] | ~r_first);
    assign w_gnt[1] = r_full[1] & (~r_full[0] |  r_first);

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_buf
            assign w_ready[g] = ~r_full[g] | w_gnt[g];
            // Writes to XZR are accepted but never occupy the buffer.
            assign w_load[g]  = w_valid[g] & w_ready[g] & (w_addr[g] != XZR);
            assign w_stay[g]  = r_full[g] & ~w_gnt[g];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_full[g] <= 1'b0;
                    r_addr[g] <= '0;
                    r_data[g] <= '0;
                end else begin
                    r_full[g] <= w_load[g] | w_stay[g];
                    if (w_load[g]) begin
                        r_addr[g] <= w_addr[g];
                        r_data[g] <= w_data[g];
                    end
                end
            end
        end
    endgenerate

    // A buffer left waiting is by definition older than anything loaded alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first <= 1'b0;
            r_rr    <= 1'b0;
        end else if (w_stay[0]) begin
            r_first <= 1'b0;
        end else if (w_stay[1]) begin
            r_first <= 1'b1;
        end else if (w_load[0] & w_load[1]) begin
            r_first <= r_rr;
            r_rr    <= ~r_rr;
        end
    end

    always_comb begin
        w_we3 = |w_gnt;
        w_wa3 = '0;
        w_wd3 = '0;
        if (w_gnt[1]) begin
            w_wa3 = r_addr[1];
            w_wd3 = r_data[1];
        end else if (w_gnt[0]) begin
            w_wa3 = r_addr[0];
            w_wd3 = r_data[0];
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NREQ; i++)
            if (r_full[i]) w_pending[r_addr[i]] = 1'b1;
        w_pending[NREGS-1] = 1'b0;
    end

    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];
    assign bus.we3        = w_we3;
    assign bus.wa3        = w_wa3;
    assign bus.wd3        = w_wd3;
    assign bus.pending    = w_pending;
    assign bus.busy       = |r_full;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a behavioural register file logs every write.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] rf [32] = '{default: '0};
    logic [4:0]  wlog_a [$];
    logic [63:0] wlog_d [$];

    always @(posedge clk) begin
        if (bus.we3) begin
            wlog_a.push_back(bus.wa3);
            wlog_d.push_back(bus.wd3);
            if (bus.wa3 != 5'd31) rf[bus.wa3] <= bus.wd3;
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int base;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.we3 !== 1'b0 || bus.pending !== 32'h0 || bus.busy !== 1'b0 ||
            bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1 || bus.wa3 !== 5'h0 || bus.wd3 !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: we3=%b wa3=%0d wd3=%h pending=%h busy=%b rdy=%b%b, need all 0 and rdy=11",
                     bus.we3, bus.wa3, bus.wd3, bus.pending, bus.busy, bus.req1_ready, bus.req0_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 64'hA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd11; bus.req1_data = 64'hB;
        base = wlog_a.size();
        @(negedge clk);
        idle_inputs();
        n_chk++;
        if (bus.busy !== 1'b1 || bus.pending !== 32'h0000_0C00) begin
            n_fail++;
            $display("FAIL reset_preload: busy=%b pending=%h, need busy=1 pending=00000c00", bus.busy, bus.pending);
        end
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (bus.we3 !== 1'b0 || bus.pending !== 32'h0 || bus.busy !== 1'b0 ||
            bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midstream: we3=%b pending=%h busy=%b rdy=%b%b, need 0/0/0/11",
                     bus.we3, bus.pending, bus.busy, bus.req1_ready, bus.req0_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (wlog_a.size() != base || rf[10] !== 64'h0 || rf[11] !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_no_stale_write: writes=%0d rf10=%h rf11=%h, need 0 writes and zeros",
                     wlog_a.size() - base, rf[10], rf[11]);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 64'hDEAD_BEEF;
        n_chk++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: req0_ready=%b, need 1", bus.req0_ready);
        end
        @(negedge clk);
        idle_inputs();
        n_chk++;
        if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd5 || bus.wd3 !== 64'hDEAD_BEEF ||
            bus.pending !== 32'h20 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: we3=%b wa3=%0d wd3=%h pending=%h busy=%b, need 1/5/deadbeef/20/1",
                     bus.we3, bus.wa3, bus.wd3, bus.pending, bus.busy);
        end
        @(negedge clk);
        n_chk++;
        if (bus.we3 !== 1'b0 || bus.wa3 !== 5'd0 || bus.wd3 !== 64'h0 ||
            bus.pending !== 32'h0 || rf[5] !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_done: we3=%b wa3=%0d wd3=%h pending=%h X5=%h, need 0/0/0/0/deadbeef",
                     bus.we3, bus.wa3, bus.wd3, bus.pending, rf[5]);
        end
    endtask

    // Two collision rounds: round-robin must flip the winner between them.
    task automatic test_collision();
        logic [4:0] first_a [2];
        logic [4:0] second_a [2];
        first_a[0] = 5'd1; second_a[0] = 5'd2;
        first_a[1] = 5'd2; second_a[1] = 5'd1;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 64'd1;
            bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 64'd2;
            n_chk++;
            if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL coll%0d_accept: rdy=%b%b, need 11", r, bus.req1_ready, bus.req0_ready);
            end
            @(negedge clk);
            idle_inputs();
            n_chk++;
            if (bus.we3 !== 1'b1 || bus.wa3 !== first_a[r] || bus.pending !== 32'h6 ||
                bus.req0_ready !== (r == 0) || bus.req1_ready !== (r == 1)) begin
                n_fail++;
                $display("FAIL coll%0d_first: we3=%b wa3=%0d pending=%h rdy=%b%b, need wa3=%0d pending=6",
                         r, bus.we3, bus.wa3, bus.pending, bus.req1_ready, bus.req0_ready, first_a[r]);
            end
            @(negedge clk);
            n_chk++;
            if (bus.we3 !== 1'b1 || bus.wa3 !== second_a[r] || bus.wd3 !== {59'd0, second_a[r]} ||
                bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL coll%0d_second: we3=%b wa3=%0d wd3=%h rdy=%b%b, need wa3=%0d rdy=11",
                         r, bus.we3, bus.wa3, bus.wd3, bus.req1_ready, bus.req0_ready, second_a[r]);
            end
            @(negedge clk);
        end
        n_chk++;
        if (bus.we3 !== 1'b0 || rf[1] !== 64'd1 || rf[2] !== 64'd2) begin
            n_fail++;
            $display("FAIL coll_result: we3=%b X1=%h X2=%h, need 0/1/2", bus.we3, rf[1], rf[2]);
        end
    endtask

    // req1 (X7=7) is left waiting while req0 is granted and refilled with X7=9.
    task automatic test_age();
        int base;
        do_reset();
        base = wlog_a.size();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 64'd1;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 64'd7;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        bus.req0_addr = 5'd7; bus.req0_data = 64'd9;
        n_chk++;
        if (bus.wa3 !== 5'd1 || bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL age_cycle1: wa3=%0d rdy=%b%b, need wa3=1 rdy=01", bus.wa3, bus.req1_ready, bus.req0_ready);
        end
        @(negedge clk);
        idle_inputs();
        n_chk++;
        if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd7 || bus.wd3 !== 64'd7 ||
            bus.req0_ready !== 1'b0 || bus.pending !== 32'h80) begin
            n_fail++;
            $display("FAIL age_older: we3=%b wa3=%0d wd3=%h req0_ready=%b pending=%h, need 1/7/7/0/80",
                     bus.we3, bus.wa3, bus.wd3, bus.req0_ready, bus.pending);
        end
        @(negedge clk);
        n_chk++;
        if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd7 || bus.wd3 !== 64'd9) begin
            n_fail++;
            $display("FAIL age_younger: we3=%b wa3=%0d wd3=%h, need 1/7/9", bus.we3, bus.wa3, bus.wd3);
        end
        @(negedge clk);
        n_chk++;
        if (wlog_a.size() != base + 3 || rf[7] !== 64'd9 || wlog_d[base+1] !== 64'd7 || wlog_d[base+2] !== 64'd9) begin
            n_fail++;
            $display("FAIL age_result: writes=%0d X7=%h, need 3 writes (1,7,9) and X7=9",
                     wlog_a.size() - base, rf[7]);
        end
    endtask

    task automatic test_xzr();
        int base;
        do_reset();
        base = wlog_a.size();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd31; bus.req0_data = 64'h1;
        n_chk++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL xzr_ready: req0_ready=%b, need 1", bus.req0_ready);
        end
        @(negedge clk);
        idle_inputs();
        n_chk++;
        if (bus.we3 !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 32'h0) begin
            n_fail++;
            $display("FAIL xzr_dropped: we3=%b busy=%b pending=%h, need 0/0/0", bus.we3, bus.busy, bus.pending);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (wlog_a.size() != base || rf[31] !== 64'h0) begin
            n_fail++;
            $display("FAIL xzr_nowrite: writes=%0d X31=%h, need 0 writes X31=0", wlog_a.size() - base, rf[31]);
        end
    endtask

    task automatic test_stream();
        int          base;
        logic [63:0] exp_d [31];
        do_reset();
        base = wlog_a.size();
        for (int i = 0; i < 31; i++) begin
            exp_d[i] = {$urandom, $urandom};
            bus.req0_valid = 1'b1; bus.req0_addr = 5'(i); bus.req0_data = exp_d[i];
            n_chk++;
            if (bus.req0_ready !== 1'b1 || (i > 0 && (bus.we3 !== 1'b1 || bus.wa3 !== 5'(i - 1)))) begin
                n_fail++;
                $display("FAIL stream_cycle%0d: req0_ready=%b we3=%b wa3=%0d, need 1/1/%0d",
                         i, bus.req0_ready, bus.we3, bus.wa3, i - 1);
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (wlog_a.size() != base + 31 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_count: writes=%0d busy=%b, need 31 writes busy=0", wlog_a.size() - base, bus.busy);
        end
        for (int i = 0; i < 31; i++) begin
            n_chk++;
            if (rf[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL stream_X%0d: got %h, need %h", i, rf[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_collision();
        test_age();
        test_xzr();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbiter that shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: req0 (ALU/EX result) and req1 (memory load result). Each requester has a one-entry holding buffer with a valid/ready handshake. Buffered writes are issued to the register file oldest-first, with a round-robin tie-break. A per-register pending mask lets the issue logic stall on registers whose writes are still in flight. The block sits between the writeback sources and the 32 x 64-bit register file.

## Interface
- DATA_W, 64, register width
- ADDR_W, 5, register address width; register 31 is XZR
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  req0 presents a write
- req0_addr  in  ADDR_W  req0 destination register
- req0_data  in  DATA_W  req0 write data
- req0_ready  out  1  req0 buffer can accept a write this cycle
- req1_valid, req1_addr, req1_data, req1_ready  same as req0, for req1
- we3  out  1  register file write enable
- wa3  out  ADDR_W  register file write address
- wd3  out  DATA_W  register file write data
- pending  out  32  bit i = 1 when a write to register i is buffered
- busy  out  1  at least one buffer is full

## Operation
- Per-requester state: full bit, addr, data.
- Shared state: first (which buffer is older), rr (tie-break pointer).
- Handshake (both requesters identical):
  - readyN = !fullN || grantN.
  - A write is accepted at a rising edge when validN && readyN.
  - validN/addr/data need only be stable while validN && !readyN.
- XZR writes: an accepted write with addr = 31 is dropped. Buffer stays empty, no we3, pending unaffected.
- Grant, combinational from registered state only (no valid-to-ready path):
  - Neither buffer full: no grant.
  - Exactly one full: grant that buffer.
  - Both full: grant the buffer named by first.
- Port drive:
  - With a grant: we3 = 1, wa3/wd3 = granted buffer's addr/data.
  - Without a grant: we3 = 0, wa3 = 0, wd3 = 0.
- Edge update:
  - The granted buffer empties, unless it is refilled at the same edge; refill is allowed.
  - first = the buffer that stays full without being refilled.
  - If both buffers are newly loaded at the same edge: first = rr, then rr toggles.
  - first and rr are otherwise unchanged.
- Same destination address in both buffers: the older buffer writes first, so the younger value ends up in the register.
- pending[i] = (full0 && addr0 == i) || (full1 && addr1 == i). pending[31] is always 0.
- busy = full0 || full1.

## Timing
- Reset (asynchronous, immediate):
  - full0 = full1 = 0, first = 0, rr = 0.
  - we3 = 0, wa3 = 0, wd3 = 0, pending = 0, busy = 0.
  - req0_ready = req1_ready = 1.
- Reset mid-operation discards buffered writes. we3 falls in the same cycle, so no partial write occurs.
- Latency:
  - Write accepted at edge E, with no competing older buffer: we3 is high during cycle E..E+1 and the register file is written at edge E+1.
  - A loser waits exactly one extra cycle per older write.
- Throughput:
  - One register file write per cycle total.
  - A single requester can sustain one write per cycle, since readyN stays 1 while its buffer is granted.
- Simultaneous events:
  - Both requesters valid with both buffers empty: both are accepted.
  - Written at E+1 and E+2, in rr order.
  - Both ready signals are 1 at the accepting edge.
- Stall: a full, ungranted buffer holds readyN = 0 until the edge at which it is granted.
- pending[i] rises after the accepting edge and clears after the edge at which the register file writes register i.

## Test plan
- Reset: reset = 0 mid-stream with both buffers full -> we3 = 0, pending = 0, busy = 0, both ready = 1 immediately. After release, no write from the old buffers ever appears.
- Single requester: req0 writes X5 = 64'hDEAD_BEEF at edge 1 -> we3 = 1, wa3 = 5, wd3 = DEAD_BEEF during cycle 1-2. pending[5] is 1 only during that cycle. Register file reads X5 = DEAD_BEEF after edge 2.
- Collision and round-robin:
  - Round 1: both valid at edge 1 (req0 X1 = 1, req1 X2 = 2) -> X1 written at edge 2, X2 at edge 3; req1_ready = 0 during cycle 1-2.
  - Round 2: the same collision again -> X2 (req1) written first.
- Age ordering, same address:
  - req1 writes X7 = 7 at edge 1 while blocked by an older req0 write.
  - req0 writes X7 = 9 at edge 2.
  - Result: writes occur in order 7 then 9; X7 reads 9 afterwards.
- XZR: req0 writes X31 = 64'h1 -> accepted (ready = 1), we3 never asserted, pending[31] = 0, X31 still reads 0.
- Streaming: req0 valid for 31 consecutive cycles writing Xi = $urandom for i = 0..30, req1 idle -> req0_ready stays 1 throughout. Each Xi reads back its value; 31 writes occur in 31 cycles.
